// File: rtl/sha3_pad_framer.sv
// sha3_pad_framer: turns a raw host message byte stream into the SHA-3
// padded byte stream (DOMAIN_PAD ... 0x80, pad10*1) over a RATE_BYTES rate,
// generating start, data_valid, last_block and frame_done for the absorber.
// Optional build macro VILYA_PAD_MSGLEN_EN enables the msg_len byte counter;
// without it msg_len is tied to zero.
module sha3_pad_framer #(
  parameter int unsigned RATE_BYTES = 136,
  parameter logic [7:0]  DOMAIN_PAD = 8'h06
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  msg_byte,
  input  logic        msg_valid,
  input  logic        msg_last,
  input  logic        msg_empty,
  output logic        msg_ready,
  input  logic        absorb_ready,
  output logic        start,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic        last_block,
  output logic        frame_done,
  output logic [15:0] msg_len
);

  localparam int unsigned IW = $clog2(RATE_BYTES);
  localparam logic [IW-1:0] LAST_IDX = IW'(RATE_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_MSG,
    S_PAD_FIRST,
    S_PAD_ZERO,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic          done_q, done_d;
  logic          empty_q, empty_d;

  logic          xfer;
  logic          slot_free;
  logic          accept;
  logic [IW-1:0] idx_inc;
  logic [IW-1:0] load_idx;

  // Handshake decode; load_idx is the block position of a byte loaded this cycle
  always_comb begin
    xfer      = valid_q && absorb_ready;
    slot_free = !valid_q || absorb_ready;
    idx_inc   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    load_idx  = xfer ? idx_inc : idx_q;
    msg_ready = (state_q == S_MSG) && slot_free;
    accept    = msg_valid && msg_ready;
  end

  // Next-state logic: FSM, output byte register, block index and flags
  always_comb begin
    state_d = state_q;
    idx_d   = xfer ? idx_inc : idx_q;
    data_d  = data_q;
    valid_d = valid_q && !absorb_ready;
    last_d  = last_q;
    done_d  = 1'b0;
    empty_d = empty_q;
    unique case (state_q)
      S_IDLE: begin
        if (msg_valid) begin
          empty_d = 1'b0;
          state_d = S_START;
        end else if (msg_empty) begin
          empty_d = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        state_d = empty_q ? S_PAD_FIRST : S_MSG;
      end
      S_MSG: begin
        if (accept) begin
          data_d  = msg_byte;
          valid_d = 1'b1;
          if (msg_last) begin
            state_d = S_PAD_FIRST;
            // A last byte filling the block pushes padding into a fresh block
            last_d  = (load_idx != LAST_IDX);
          end
        end
      end
      S_PAD_FIRST: begin
        if (slot_free) begin
          valid_d = 1'b1;
          last_d  = 1'b1;
          if (load_idx == LAST_IDX) begin
            data_d  = DOMAIN_PAD | 8'h80;
            state_d = S_DONE;
          end else begin
            data_d  = DOMAIN_PAD;
            state_d = S_PAD_ZERO;
          end
        end
      end
      S_PAD_ZERO: begin
        if (slot_free) begin
          valid_d = 1'b1;
          if (load_idx == LAST_IDX) begin
            data_d  = 8'h80;
            state_d = S_DONE;
          end else begin
            data_d  = 8'h00;
          end
        end
      end
      S_DONE: begin
        if (xfer) begin
          done_d  = 1'b1;
          last_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      empty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
      empty_q <= empty_d;
    end
  end

  assign start      = (state_q == S_START);
  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign last_block = last_q;
  assign frame_done = done_q;

`ifdef VILYA_PAD_MSGLEN_EN
  logic [15:0] len_q, len_d;

  // Accepted-byte counter: cleared on start, saturating, held until next start
  always_comb begin
    len_d = len_q;
    if (state_q == S_START) begin
      len_d = '0;
    end else if (accept && (len_q != 16'hFFFF)) begin
      len_d = len_q + 16'd1;
    end
  end

  // Message length register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q <= '0;
    end else begin
      len_q <= len_d;
    end
  end

  assign msg_len = len_q;
`else
  assign msg_len = '0;
`endif

endmodule

// File: tb/tb_sha3_pad_framer.sv
// Self-checking bench for sha3_pad_framer: random messages and random
// absorber backpressure against a padded-stream reference model.
module tb_sha3_pad_framer;
  localparam int R = 136;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  msg_byte = '0;
  logic        msg_valid = 1'b0;
  logic        msg_last = 1'b0;
  logic        msg_empty = 1'b0;
  logic        msg_ready;
  logic        absorb_ready = 1'b0;
  logic        start;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        last_block;
  logic        frame_done;
  logic [15:0] msg_len;

  sha3_pad_framer #(.RATE_BYTES(R), .DOMAIN_PAD(8'h06)) dut (
    .clk(clk), .rst_n(rst_n), .msg_byte(msg_byte), .msg_valid(msg_valid),
    .msg_last(msg_last), .msg_empty(msg_empty), .msg_ready(msg_ready),
    .absorb_ready(absorb_ready), .start(start), .data_out(data_out),
    .data_valid(data_valid), .last_block(last_block),
    .frame_done(frame_done), .msg_len(msg_len)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Per-frame bookkeeping
  logic [7:0] msg[$];
  logic [7:0] exp_data[$];
  bit         exp_last[$];
  logic [7:0] got_data[$];
  bit         got_last[$];
  int         mptr;
  int         start_cnt;
  int         done_cnt;
  int         stretch;
  bit         prev_stalled;
  logic [7:0] prev_data;
  bit         empty_pulse;

  // Reference: message followed by pad10*1 with domain byte 0x06
  task automatic build_expected(input int len);
    int pad, total;
    exp_data.delete();
    exp_last.delete();
    foreach (msg[i]) exp_data.push_back(msg[i]);
    pad = R - (len % R);
    if (pad == 1) begin
      exp_data.push_back(8'h86);
    end else begin
      exp_data.push_back(8'h06);
      for (int i = 0; i < pad - 2; i++) exp_data.push_back(8'h00);
      exp_data.push_back(8'h80);
    end
    total = exp_data.size();
    for (int k = 0; k < total; k++)
      exp_last.push_back((k >= total - R) && (k + 1 >= len));
  endtask

  // One clock cycle: drive after the edge, observe on the falling edge
  task automatic step(input bit stall_mode);
    @(posedge clk);
    #1;
    if (stall_mode) begin
      if (stretch > 0) begin
        absorb_ready = 1'b0;
        stretch--;
      end else if ($urandom_range(0, 29) == 0) begin
        absorb_ready = 1'b0;
        stretch = 16;
      end else begin
        absorb_ready = 1'($urandom_range(0, 1));
      end
    end else begin
      absorb_ready = 1'b1;
    end
    msg_empty = empty_pulse;
    empty_pulse = 1'b0;
    if (mptr < msg.size()) begin
      msg_valid = (mptr == 0) ? 1'b1 : (stall_mode ? ($urandom_range(0, 3) != 0) : 1'b1);
      msg_byte  = msg_valid ? msg[mptr] : 8'($urandom);
      msg_last  = (mptr == msg.size() - 1);
    end else begin
      msg_valid = 1'b0;
      msg_last  = 1'b0;
      msg_byte  = 8'($urandom);
    end
    @(negedge clk);
    if (msg_valid && msg_ready) mptr++;
    if (prev_stalled) begin
      check_eq("stall_valid_held", 32'(data_valid), 32'd1);
      check_eq("stall_data_held", 32'(data_out), 32'(prev_data));
    end
    prev_stalled = data_valid && !absorb_ready;
    prev_data    = data_out;
    if (start) begin
      start_cnt++;
      check_eq("start_before_data", got_data.size(), 0);
    end
    if (data_valid && absorb_ready) begin
      got_data.push_back(data_out);
      got_last.push_back(last_block);
    end
    if (frame_done) done_cnt++;
  endtask

  task automatic run_frame(input int len, input bit use_abc, input bit stall_mode, input int abort_after);
    int cyc;
    msg.delete();
    got_data.delete();
    got_last.delete();
    if (use_abc) begin
      msg.push_back(8'h61);
      msg.push_back(8'h62);
      msg.push_back(8'h63);
    end else begin
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
    end
    build_expected(len);
    mptr = 0;
    start_cnt = 0;
    done_cnt = 0;
    stretch = 0;
    prev_stalled = 1'b0;
    empty_pulse = (len == 0);
    cyc = 0;
    while (cyc < 4000 && done_cnt == 0 && !(abort_after > 0 && got_data.size() >= abort_after)) begin
      step(stall_mode);
      cyc++;
    end
    if (abort_after > 0) return;
    for (int i = 0; i < 3; i++) step(stall_mode);
    check_eq($sformatf("frame_done_count len=%0d", len), done_cnt, 1);
    check_eq($sformatf("start_count len=%0d", len), start_cnt, 1);
    check_eq($sformatf("xfer_count len=%0d", len), got_data.size(), exp_data.size());
    for (int k = 0; k < got_data.size() && k < exp_data.size(); k++) begin
      check_eq($sformatf("data len=%0d k=%0d", len, k), 32'(got_data[k]), 32'(exp_data[k]));
      check_eq($sformatf("last_block len=%0d k=%0d", len, k), 32'(got_last[k]), 32'(exp_last[k]));
    end
`ifdef VILYA_PAD_MSGLEN_EN
    check_eq($sformatf("msg_len len=%0d", len), 32'(msg_len), len);
`else
    check_eq($sformatf("msg_len len=%0d", len), 32'(msg_len), 32'd0);
`endif
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_data_valid"}, 32'(data_valid), 32'd0);
    check_eq({tag, "_data_out"}, 32'(data_out), 32'd0);
    check_eq({tag, "_last_block"}, 32'(last_block), 32'd0);
    check_eq({tag, "_start"}, 32'(start), 32'd0);
    check_eq({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check_eq({tag, "_msg_ready"}, 32'(msg_ready), 32'd0);
    check_eq({tag, "_msg_len"}, 32'(msg_len), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_frame(0, 1'b0, 1'b0, 0);
    run_frame(3, 1'b1, 1'b0, 0);
    run_frame(135, 1'b0, 1'b0, 0);
    run_frame(136, 1'b0, 1'b0, 0);
    run_frame(3, 1'b1, 1'b1, 0);
    run_frame(136, 1'b0, 1'b1, 0);
    run_frame(135, 1'b0, 1'b1, 0);
    run_frame(1, 1'b0, 1'b1, 0);
    for (int n = 0; n < 3; n++) run_frame($urandom_range(2, 300), 1'b0, 1'b1, 0);

    // Abort in the middle of the zero padding
    run_frame(0, 1'b0, 1'b0, 20);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midframe_reset");
    msg_valid = 1'b0;
    msg_empty = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_frame(0, 1'b0, 1'b0, 0);
    run_frame(3, 1'b1, 1'b1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
